// File: rtl/bicubic_seq_ctrl_if.sv
// Handshake/data bundle between the bicubic sequencer, its row source,
// the shared 4-tap MAC, the 2:1 mux bank and the pixel sink.
interface bicubic_seq_ctrl_if;
    logic        start;
    logic [15:0] cfg_count;
    logic        row_valid;
    logic        row_ready;
    logic [16:0] mac_result;
    logic        mac_en;
    logic        switch;
    logic [16:0] hbuf_0;
    logic [16:0] hbuf_1;
    logic [16:0] hbuf_2;
    logic [16:0] hbuf_3;
    logic [16:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        done;

    modport master (
        output start, cfg_count, row_valid, mac_result, pix_ready,
        input  row_ready, mac_en, switch, hbuf_0, hbuf_1, hbuf_2, hbuf_3,
               pix_data, pix_valid, busy, done
    );

    modport slave (
        input  start, cfg_count, row_valid, mac_result, pix_ready,
        output row_ready, mac_en, switch, hbuf_0, hbuf_1, hbuf_2, hbuf_3,
               pix_data, pix_valid, busy, done
    );
endinterface

// File: rtl/bicubic_seq_ctrl.sv
// Bicubic sequencer: four horizontal MAC passes into hbuf_0..3, then one
// vertical MAC pass over the hbufs, per output pixel, on a shared MAC.
module bicubic_seq_ctrl #(
    parameter int MAC_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    bicubic_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, HPASS, HWAIT, VPASS, VWAIT, OUT} state_t;

    localparam logic [1:0] VLAST = 2'(MAC_LAT - 1);

    state_t       r_state;
    logic         r_row_ready;
    logic         r_switch;
    logic         r_pix_valid;
    logic         r_busy;
    logic         r_done;
    logic [15:0]  r_cfg;
    logic [15:0]  r_cnt;
    logic [1:0]   r_row;
    logic [1:0]   r_vcnt;
    logic [16:0]  r_pix_data;
    logic [16:0]  r_hbuf [4];
    logic [MAC_LAT-1:0] r_tv;
    logic [1:0]   r_tt [MAC_LAT];

    logic         w_row_acc;
    logic         w_cap;
    logic [1:0]   w_cap_tag;

    assign w_row_acc = (r_state == HPASS) && bus.row_valid && r_row_ready;
    assign w_cap     = r_tv[MAC_LAT-1];
    assign w_cap_tag = r_tt[MAC_LAT-1];

    // Tag line tracks which hbuf each in-flight horizontal MAC result belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tv <= '0;
            for (int i = 0; i < MAC_LAT; i++) r_tt[i] <= '0;
            for (int i = 0; i < 4; i++) r_hbuf[i] <= '0;
        end else begin
            r_tv[0] <= w_row_acc;
            r_tt[0] <= r_row;
            for (int i = 1; i < MAC_LAT; i++) begin
                r_tv[i] <= r_tv[i-1];
                r_tt[i] <= r_tt[i-1];
            end
            if (w_cap) r_hbuf[w_cap_tag] <= bus.mac_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_row_ready <= 1'b0;
            r_switch    <= 1'b0;
            r_pix_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg       <= '0;
            r_cnt       <= '0;
            r_row       <= '0;
            r_vcnt      <= '0;
            r_pix_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_cfg <= bus.cfg_count;
                        r_cnt <= '0;
                        if (bus.cfg_count != 16'd0) begin
                            r_state     <= HPASS;
                            r_row_ready <= 1'b1;
                            r_busy      <= 1'b1;
                            r_row       <= '0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                HPASS: begin
                    if (w_row_acc) begin
                        r_row <= r_row + 2'd1;
                        if (r_row == 2'd3) begin
                            r_state     <= HWAIT;
                            r_row_ready <= 1'b0;
                        end
                    end
                end
                HWAIT: begin
                    if (w_cap && (w_cap_tag == 2'd3)) begin
                        r_state  <= VPASS;
                        r_switch <= 1'b1;
                    end
                end
                VPASS: begin
                    r_state <= VWAIT;
                    r_vcnt  <= '0;
                end
                VWAIT: begin
                    if (r_vcnt == VLAST) begin
                        r_pix_data  <= bus.mac_result;
                        r_state     <= OUT;
                        r_switch    <= 1'b0;
                        r_pix_valid <= 1'b1;
                    end else begin
                        r_vcnt <= r_vcnt + 2'd1;
                    end
                end
                OUT: begin
                    if (bus.pix_ready) begin
                        r_pix_valid <= 1'b0;
                        if (r_cnt == r_cfg - 16'd1) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt       <= r_cnt + 16'd1;
                            r_state     <= HPASS;
                            r_row_ready <= 1'b1;
                            r_row       <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.row_ready = r_row_ready;
    assign bus.mac_en    = w_row_acc || (r_state == VPASS);
    assign bus.switch    = r_switch;
    assign bus.hbuf_0    = r_hbuf[0];
    assign bus.hbuf_1    = r_hbuf[1];
    assign bus.hbuf_2    = r_hbuf[2];
    assign bus.hbuf_3    = r_hbuf[3];
    assign bus.pix_data  = r_pix_data;
    assign bus.pix_valid = r_pix_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_bicubic_seq_ctrl.sv
// Directed bench: three controllers (MAC_LAT 1, 3, 2) each driving a behavioural
// MAC that sums the four mux outputs; rows of identical pixels per window row.
module tb_bicubic_seq_ctrl;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] t_start = '0;
    logic [NI-1:0] t_rven  = '0;
    logic [NI-1:0] t_tog   = '0;
    logic [NI-1:0] t_prdy  = '0;
    logic [15:0]   t_cfg [NI];
    int            t_off [NI];
    logic          phase = 1'b0;
    logic [NI-1:0] w_rv;

    logic [NI-1:0] o_rr, o_me, o_sw, o_pv, o_busy, o_done;
    logic [16:0]   o_h  [NI][4];
    logic [16:0]   o_pd [NI];
    logic [16:0]   m_pipe [NI][4];

    int acc [NI];
    int n_mac [NI];
    int n_done [NI];
    int n_pix [NI];
    int n_bad [NI];
    int vp_h3 [NI];
    int n_cmp = 0;
    int n_err = 0;

    assign w_rv = t_rven & (~t_tog | {NI{phase}});

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 2;
        bicubic_seq_ctrl_if u_if ();
        bicubic_seq_ctrl #(.MAC_LAT(LAT)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if.slave)
        );
        assign u_if.start      = t_start[g];
        assign u_if.cfg_count  = t_cfg[g];
        assign u_if.row_valid  = w_rv[g];
        assign u_if.pix_ready  = t_prdy[g];
        assign u_if.mac_result = m_pipe[g][LAT-1];
        assign o_rr[g]   = u_if.row_ready;
        assign o_me[g]   = u_if.mac_en;
        assign o_sw[g]   = u_if.switch;
        assign o_pv[g]   = u_if.pix_valid;
        assign o_busy[g] = u_if.busy;
        assign o_done[g] = u_if.done;
        assign o_h[g][0] = u_if.hbuf_0;
        assign o_h[g][1] = u_if.hbuf_1;
        assign o_h[g][2] = u_if.hbuf_2;
        assign o_h[g][3] = u_if.hbuf_3;
        assign o_pd[g]   = u_if.pix_data;
    end

    // Row r of each window carries pixel value r+1+offset on all four taps.
    function automatic logic [16:0] mac_in(int g);
        logic [16:0] p;
        p = 17'((acc[g] & 3) + 1 + t_off[g]);
        if (o_sw[g]) return o_h[g][0] + o_h[g][1] + o_h[g][2] + o_h[g][3];
        return 17'(4 * p);
    endfunction

    always @(posedge clk) begin
        phase <= ~phase;
        for (int g = 0; g < NI; g++) begin
            m_pipe[g][0] <= mac_in(g);
            for (int k = 1; k < 4; k++) m_pipe[g][k] <= m_pipe[g][k-1];
            if (!rst_n) acc[g] <= 0;
            else if (w_rv[g] && o_rr[g]) acc[g] <= acc[g] + 1;
            if (o_me[g]) n_mac[g] <= n_mac[g] + 1;
            if (o_done[g]) n_done[g] <= n_done[g] + 1;
            if (o_pv[g] && t_prdy[g]) n_pix[g] <= n_pix[g] + 1;
            if (o_sw[g] && o_rr[g]) n_bad[g] <= n_bad[g] + 1;
            if (o_me[g] && o_sw[g]) vp_h3[g] <= int'(o_h[g][3]);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d exp %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input int g, input int cfg);
        t_cfg[g]   = 16'(cfg);
        t_start[g] = 1'b1;
        @(negedge clk);
        t_start[g] = 1'b0;
    endtask

    task automatic wait_pv(input int g, input int bound, output int cyc);
        cyc = 0;
        while (!o_pv[g] && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take(input int g);
        t_prdy[g] = 1'b1;
        @(negedge clk);
        t_prdy[g] = 1'b0;
    endtask

    initial begin
        int cyc, base_d, base_p, base_m, stable;
        for (int g = 0; g < NI; g++) begin
            t_cfg[g] = '0;
            t_off[g] = 0;
        end
        tick(2);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rst_busy%0d", g), o_busy[g], 0);
            chk($sformatf("rst_rr%0d", g), o_rr[g], 0);
            chk($sformatf("rst_pv%0d", g), o_pv[g], 0);
            chk($sformatf("rst_h0_%0d", g), o_h[g][0], 0);
        end

        // Start in the very cycle reset is released, continuous rows, MAC_LAT=1.
        t_rven[0] = 1'b1;
        rst_n = 1'b1;
        go(0, 1);
        wait_pv(0, 40, cyc);
        chk("t1_lat", cyc, 7);
        chk("t1_h0", o_h[0][0], 4);
        chk("t1_h1", o_h[0][1], 8);
        chk("t1_h2", o_h[0][2], 12);
        chk("t1_h3", o_h[0][3], 16);
        chk("t1_pd", o_pd[0], 40);
        chk("t1_busy_out", o_busy[0], 1);
        take(0);
        chk("t1_done", o_done[0], 1);
        chk("t1_busy_end", o_busy[0], 0);
        tick(3);
        chk("t1_ndone", n_done[0], 1);
        chk("t1_nmac", n_mac[0], 5);

        // MAC_LAT=3 with rows arriving every other cycle.
        t_rven[1] = 1'b1;
        t_tog[1]  = 1'b1;
        go(1, 1);
        wait_pv(1, 100, cyc);
        chk("t2_pv", o_pv[1], 1);
        chk("t2_h0", o_h[1][0], 4);
        chk("t2_h1", o_h[1][1], 8);
        chk("t2_h2", o_h[1][2], 12);
        chk("t2_h3", o_h[1][3], 16);
        chk("t2_pd", o_pd[1], 40);
        chk("t2_sw_rr", n_bad[1], 0);
        chk("t2_vpass_h3", vp_h3[1], 16);
        take(1);
        chk("t2_done", o_done[1], 1);
        tick(2);
        chk("t2_nmac", n_mac[1], 5);

        // Three pixels, restart and cfg change while busy, stalled sink on pixel 2.
        t_off[0] = 1;
        base_d = n_done[0];
        base_p = n_pix[0];
        go(0, 3);
        t_cfg[0]   = 16'd7;
        t_start[0] = 1'b1;
        @(negedge clk);
        t_start[0] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wait_pv(0, 60, cyc);
            chk($sformatf("t3_pd%0d", p), o_pd[0], 56);
            if (p == 1) begin
                stable = 1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (o_pd[0] != 17'd56 || !o_pv[0] || o_rr[0]) stable = 0;
                end
                chk("t3_hold", stable, 1);
            end
            take(0);
        end
        chk("t3_done", o_done[0], 1);
        chk("t3_busy", o_busy[0], 0);
        tick(4);
        chk("t3_npix", n_pix[0] - base_p, 3);
        chk("t3_ndone", n_done[0] - base_d, 1);
        chk("t3_h3_keep", o_h[0][3], 20);

        // Empty job: no busy, no MAC, single done pulse.
        base_d = n_done[0];
        base_m = n_mac[0];
        go(0, 0);
        chk("t4_busy", o_busy[0], 0);
        chk("t4_done", o_done[0], 1);
        tick(1);
        chk("t4_done_off", o_done[0], 0);
        chk("t4_ndone", n_done[0] - base_d, 1);
        chk("t4_nmac", n_mac[0] - base_m, 0);

        // Reset asserted during HWAIT with MAC results still in flight.
        t_rven[2] = 1'b1;
        go(2, 1);
        cyc = 0;
        while (!(o_busy[2] && !o_rr[2]) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_hwait", int'(o_busy[2] && !o_rr[2] && !o_sw[2]), 1);
        chk("t5_h1_pre", o_h[2][1], 8);
        rst_n = 1'b0;
        #1;
        chk("t5_rr", o_rr[2], 0);
        chk("t5_me", o_me[2], 0);
        chk("t5_sw", o_sw[2], 0);
        chk("t5_pv", o_pv[2], 0);
        chk("t5_busy", o_busy[2], 0);
        chk("t5_done", o_done[2], 0);
        chk("t5_h1", o_h[2][1], 0);
        chk("t5_pd", o_pd[2], 0);
        @(negedge clk);
        rst_n = 1'b1;
        base_m = n_mac[2];
        tick(10);
        chk("t5_h0_post", o_h[2][0], 0);
        chk("t5_h2_post", o_h[2][2], 0);
        chk("t5_h3_post", o_h[2][3], 0);
        chk("t5_busy_post", o_busy[2], 0);
        chk("t5_nmac_post", n_mac[2] - base_m, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bicubic_seq_ctrl.md
BICUBIC_SEQ_CTRL -- requirements
Module: bicubic_seq_ctrl

Interface
REQ-001 Parameter MAC_LAT, default 1, legal 1..4: cycles from mac_en high to matching mac_result valid.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; begins a job when IDLE.
REQ-005 cfg_count  input  16  output pixels in the job; sampled only on accepted start.
REQ-006 row_valid  input  1  upstream presents one 4-pixel window row on the 2:1 mux bank-0 inputs.
REQ-007 row_ready  output  1  controller accepts the row this cycle.
REQ-008 mac_result  input  17  shared 4-tap MAC output.
REQ-009 mac_en  output  1  MAC consumes the current mux outputs this cycle.
REQ-010 switch  output  1  mux select: 0 = bank 0 (row pixels), 1 = bank 1 (hbuf_0..3).
REQ-011 hbuf_0, hbuf_1, hbuf_2, hbuf_3  output  17 each  captured horizontal-pass results, wired to mux bank-1 inputs.
REQ-012 pix_data  output  17  final interpolated pixel.
REQ-013 pix_valid  output  1  pix_data valid.
REQ-014 pix_ready  input  1  downstream accepts pix_data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at job end.

Function
REQ-017 States: IDLE, HPASS, HWAIT, VPASS, VWAIT, OUT.
REQ-018 IDLE: start=1 latches cfg_count, clears pixel counter; goes HPASS if cfg_count!=0, else stays IDLE and pulses done the next cycle.
REQ-019 start outside IDLE is ignored.
REQ-020 HPASS: row_ready=1, switch=0; each row_valid&row_ready cycle drives mac_en=1 and tags row index r (0..3, increments per accept).
REQ-021 HPASS: after the 4th accept (r=3), next state HWAIT; row_ready=0 in all other states.
REQ-022 Capture: a mac_en issued in cycle t with tag r writes mac_result into hbuf_r at the edge ending cycle t+MAC_LAT; implemented with a MAC_LAT-deep valid/tag shift line.
REQ-023 HWAIT: stays until hbuf_3 captured, then VPASS; row_valid gaps in HPASS only stall, never reorder tags.
REQ-024 VPASS: exactly one cycle, switch=1, mac_en=1; next VWAIT.
REQ-025 VWAIT: switch=1 held; mac_en=0; after MAC_LAT cycles, mac_result registered into pix_data, next OUT.
REQ-026 OUT: pix_valid=1, pix_data stable until pix_valid&pix_ready.
REQ-027 On OUT handshake: if pixel counter = latched cfg_count-1, done=1 that cycle's next edge, return IDLE; else increment counter, go HPASS with r=0.
REQ-028 switch=0 and mac_en=0 whenever not in HPASS-accept or VPASS/VWAIT per above.
REQ-029 Counter 16-bit, no wrap: cfg_count=16'hFFFF completes exactly 65535 pixels.
REQ-030 hbuf_* retain values between pixels; overwritten only by capture.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE; row_ready, mac_en, switch, pix_valid, busy, done = 0; hbuf_0..3, pix_data, counter, tags, shift line = 0.
REQ-032 Reset mid-job discards in-flight MAC results; no capture occurs after rst_n release until new mac_en issued.
REQ-033 Outputs valid from first rising edge after rst_n deasserts; start in that cycle is accepted.

Verification
REQ-034 MAC_LAT=1, cfg_count=1, rows continuous, MAC model = sum of four pixels, rows {1,1,1,1},{2,2,2,2},{3,3,3,3},{4,4,4,4}, V-pass model = sum of hbufs -> hbuf_0..3=4,8,12,16; pix_data=40; pix_valid 8 cycles after start; done once.
REQ-035 MAC_LAT=3, row_valid toggling 1/0 -> hbuf tags correct, switch never 1 while row_ready=1, VPASS entered only after hbuf_3 written.
REQ-036 cfg_count=3, pix_ready held low 5 cycles on pixel 2 -> pix_data constant, no row_ready, exactly 3 accepted pixels, done after third.
REQ-037 cfg_count=0 -> busy stays 0, no mac_en, done pulses once.
REQ-038 rst_n low during HWAIT, MAC_LAT=2 -> all outputs zero immediately; after release, no hbuf change without new start.
REQ-039 start pulsed while busy -> ignored; cfg_count change mid-job has no effect.
